pmod_uart_tx: RTL and testbench

- UART transmitter (8N1, LSB first) with an input byte FIFO; drives the `pmod_uart_txd` pin of the Arty A7-100T top level.
- Sits inside the block design between the MicroBlaze/EEMBC host-interface logic and the board wrapper port.
- Accepts bytes on an AXI4-Stream slave and serialises them back-to-back.
- Gives the EEMBC runner a UART path that needs no CPU polling per bit.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/pmod_uart_tx.sv | 119 +++++++++++
 tb/tb_pmod_uart_tx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the PMOD UART transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Clock cycles per bit, rounded to nearest.
    function automatic int unsigned baud_div(
        input int unsigned clk_hz,
        input int unsigned baud
    );
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count and fall-through read data.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_check
        $error("sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (AW + 1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pmod_uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO on an AXI4-Stream slave.
module pmod_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                        sys_clock,
    input  logic                        reset,
    input  logic [UART_DATA_BITS-1:0]   s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic                        pmod_uart_txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned DIV = baud_div(CLK_FREQ_HZ, BAUD);
    localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

    if (DIV < 2) begin : g_div_check
        $error("pmod_uart_tx: CLK_FREQ_HZ/BAUD gives fewer than 2 cycles per bit");
    end

    uart_state_t               state;
    logic [CW-1:0]             baud_cnt;
    logic [UART_DATA_BITS-1:0] shift;
    logic [2:0]                bit_idx;
    logic                      txd_q;
    logic [UART_DATA_BITS-1:0] fifo_data;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      wrap;
    logic                      pop;

    assign wrap = baud_cnt == CNT_LAST;
    // A new byte is taken from IDLE or straight out of a finishing stop bit.
    assign pop  = !fifo_empty &&
                  (state == IDLE || (state == STOP && wrap));

    assign s_axis_tready = !fifo_full;
    assign pmod_uart_txd = txd_q;
    assign busy          = (state != IDLE) || (fifo_count != '0);

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clock),
        .reset   (reset),
        .push    (s_axis_tvalid && s_axis_tready),
        .pop     (pop),
        .wr_data (s_axis_tdata),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            shift    <= '0;
            bit_idx  <= '0;
            txd_q    <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift    <= fifo_data;
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    txd_q <= 1'b0;
                    if (wrap) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    txd_q <= shift[0];
                    if (wrap) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        if (bit_idx == BIT_LAST) state <= STOP;
                        else bit_idx <= bit_idx + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    txd_q <= 1'b1;
                    if (wrap) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= fifo_data;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmod_uart_tx.sv
// Directed bench for pmod_uart_tx at DIV=10, FIFO_DEPTH=4.
module tb_pmod_uart_tx;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] tdata  = 8'h00;
    logic       tvalid = 1'b0;
    logic       tready;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    pmod_uart_tx #(
        .CLK_FREQ_HZ (1_000_000),
        .BAUD        (100_000),
        .FIFO_DEPTH  (4)
    ) dut (
        .sys_clock     (clk),
        .reset         (reset),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .pmod_uart_txd (txd),
        .busy          (busy),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] six  [6];
    logic [7:0] fill [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset  = 1'b1;
        tvalid = 1'b0;
        step_n(2);
        chk("rst txd", 32'(txd), 32'd1);
        chk("rst tready", 32'(tready), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst count", 32'(fifo_count), 32'd0);
        reset = 1'b0;
        step();
    endtask

    // Called on the first start-bit cycle; returns on the last stop cycle.
    task automatic expect_frame(input logic [7:0] d, input logic [9:0] fr,
                                input string tag);
        logic [7:0] got;
        logic       bad;
        got = '0;
        for (int j = 0; j < 10; j++) begin
            bad = 1'b0;
            for (int c = 0; c < 10; c++) begin
                if (txd !== fr[j]) bad = 1'b1;
                if (c == 5 && j >= 1 && j <= 8) got[j-1] = txd;
                if (!(j == 9 && c == 9)) step();
            end
            chk($sformatf("%s bit%0d", tag, j), 32'(bad), 32'd0);
        end
        chk({tag, " data"}, 32'(got), 32'(d));
    endtask

    task automatic rx_byte(output logic [7:0] d, input string tag);
        int n;
        n = 0;
        d = '0;
        while (txd !== 1'b0 && n < 3000) begin
            step();
            n++;
        end
        chk({tag, " start seen"}, 32'(txd), 32'd0);
        if (txd !== 1'b0) return;
        step_n(5);
        for (int b = 0; b < 8; b++) begin
            step_n(10);
            d[b] = txd;
        end
        step_n(10);
        chk({tag, " stop"}, 32'(txd), 32'd1);
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] rx;
        int         bad;
        int         idx;
        int         guard;
        logic       fire;
        logic       saw_full;

        vecs[0] = '{8'h55, 10'b1010101010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h81, 10'b1100000010};
        vecs[4] = '{8'hA3, 10'b1101000110};
        six  = '{8'h11, 8'h22, 8'h3C, 8'hC3, 8'h5A, 8'h96};
        fill = '{8'hE1, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};

        // Reset and idle
        apply_reset();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (txd !== 1'b1 || tready !== 1'b1 || busy !== 1'b0 ||
                fifo_count !== 3'd0) bad++;
            step();
        end
        chk("idle 50 cycles", 32'(bad), 32'd0);

        // Single frames with exact latency
        for (int v = 0; v < 5; v++) begin
            apply_reset();
            tdata  = vecs[v].data;
            tvalid = 1'b1;
            step();
            tvalid = 1'b0;
            chk($sformatf("v%0d count N+1", v), 32'(fifo_count), 32'd1);
            chk($sformatf("v%0d busy N+1", v), 32'(busy), 32'd1);
            step();
            chk($sformatf("v%0d count N+2", v), 32'(fifo_count), 32'd0);
            chk($sformatf("v%0d txd N+2", v), 32'(txd), 32'd1);
            step();
            expect_frame(vecs[v].data, vecs[v].frame, $sformatf("v%0d", v));
            chk($sformatf("v%0d busy end", v), 32'(busy), 32'd0);
            step();
            chk($sformatf("v%0d txd after", v), 32'(txd), 32'd1);
        end

        // Three bytes back to back, no idle gap
        apply_reset();
        tvalid = 1'b1;
        tdata  = 8'hA3;
        step();
        tdata  = 8'h0F;
        step();
        tdata  = 8'hFF;
        step();
        tvalid = 1'b0;
        chk("b2b count", 32'(fifo_count), 32'd2);
        expect_frame(8'hA3, 10'b1101000110, "b2b0");
        step();
        expect_frame(8'h0F, 10'b1000011110, "b2b1");
        step();
        expect_frame(8'hFF, 10'b1111111110, "b2b2");
        chk("b2b busy end", 32'(busy), 32'd0);

        // Producer holds tvalid through backpressure
        apply_reset();
        idx      = 0;
        guard    = 0;
        bad      = 0;
        saw_full = 1'b0;
        fork
            begin
                while (idx < 6 && guard < 2000) begin
                    tdata  = six[idx];
                    tvalid = 1'b1;
                    if (tready !== (fifo_count != 3'd4)) bad++;
                    if (fifo_count == 3'd4) saw_full = 1'b1;
                    fire = tready;
                    step();
                    guard++;
                    if (fire) idx++;
                end
                tvalid = 1'b0;
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    rx_byte(rx, $sformatf("hold%0d", k));
                    chk($sformatf("hold byte%0d", k), 32'(rx), 32'(six[k]));
                end
            end
        join
        chk("hold tready vs full", 32'(bad), 32'd0);
        chk("hold saw full", 32'(saw_full), 32'd1);
        chk("hold accepted", 32'(idx), 32'd6);
        step_n(20);
        chk("hold busy end", 32'(busy), 32'd0);

        // Reset during bit 4 of 0x81 with two bytes queued
        apply_reset();
        tvalid = 1'b1;
        tdata  = 8'h81;
        step();
        tdata  = 8'h11;
        step();
        tdata  = 8'h22;
        step();
        tvalid = 1'b0;
        step_n(53);
        chk("midrst bit4", 32'(txd), 32'd0);
        chk("midrst queued", 32'(fifo_count), 32'd2);
        reset = 1'b1;
        step();
        chk("midrst txd", 32'(txd), 32'd1);
        chk("midrst count", 32'(fifo_count), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("midrst quiet", 32'(bad), 32'd0);

        // Push at full while the FSM pops on the same edge
        apply_reset();
        tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tdata = fill[i];
            step();
        end
        tdata = fill[5];
        chk("full count", 32'(fifo_count), 32'd4);
        chk("full tready", 32'(tready), 32'd0);
        step_n(96);
        chk("pre-pop tready", 32'(tready), 32'd0);
        chk("pre-pop count", 32'(fifo_count), 32'd4);
        step();
        chk("pop count", 32'(fifo_count), 32'd3);
        chk("pop tready", 32'(tready), 32'd1);
        step();
        tvalid = 1'b0;
        chk("refill count", 32'(fifo_count), 32'd4);
        for (int k = 1; k < 6; k++) begin
            rx_byte(got, $sformatf("full%0d", k));
            chk($sformatf("full byte%0d", k), 32'(got), 32'(fill[k]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
